// File: rtl/phy_rx_lane.sv
// phy_rx_lane: serial-to-parallel receive end of one PHY lane with COM-based byte alignment
// clk_32f     in   bit clock, all logic on posedge
// reset_L     in   synchronous active-low reset
// data_in     in   serial lane bit, MSB of each byte first
// data_out    out  last received data byte, held between boundaries
// valid_out   out  data_out holds a data byte (neither COM nor IDL)
// byte_strobe out  one-cycle pulse on each byte boundary once aligned
// active      out  alignment lock achieved, held until reset
module phy_rx_lane #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] IDL      = 8'h7C,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
  state_t      r_state;
  logic [7:0]  r_sr;
  logic [2:0]  r_bit_cnt;
  logic [3:0]  r_com_cnt;
  logic [7:0]  w_nxt;
  logic [3:0]  w_com_inc;
  logic        w_bnd;
  logic        w_ctrl;
  assign w_nxt     = {r_sr[6:0], data_in};
  assign w_com_inc = r_com_cnt + 4'd1;
  assign w_bnd     = r_bit_cnt == 3'd7;
  assign w_ctrl    = (w_nxt == COM) || (w_nxt == IDL);
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      r_state     <= SEARCH;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_com_cnt   <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      r_sr        <= w_nxt;
      r_bit_cnt   <= r_bit_cnt + 3'd1;
      byte_strobe <= 1'b0;
      case (r_state)
        SEARCH: if (w_nxt == COM) begin
          // this edge becomes the byte boundary, so the next one is 8 cycles out
          r_bit_cnt <= 3'd0;
          r_com_cnt <= 4'd1;
          active    <= BC_COUNT == 1;
          r_state   <= BC_COUNT == 1 ? ACTIVE : ALIGN;
        end
        ALIGN: if (w_bnd) begin
          if (w_nxt == COM) begin
            r_com_cnt <= w_com_inc;
            if (w_com_inc == 4'(BC_COUNT)) begin
              active  <= 1'b1;
              r_state <= ACTIVE;
            end
          end else begin
            r_com_cnt <= 4'd0;
            r_state   <= SEARCH;
          end
        end
        ACTIVE: if (w_bnd) begin
          byte_strobe <= 1'b1;
          valid_out   <= !w_ctrl;
          data_out    <= w_ctrl ? data_out : w_nxt;
        end
        default: r_state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_phy_rx_lane.sv
// tb_phy_rx_lane: directed and randomized checks of phy_rx_lane against a timestamp-based lane model
module tb_phy_rx_lane;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
  localparam int         BC  = 4;
  logic       clk_32f;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  int vectors;
  int miscompares;
  int strobes;
  bit hist[$];
  int t_now;
  int anchor;
  int coms;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_strobe;
  logic       m_act;
  phy_rx_lane #(.COM(COM), .IDL(IDL), .BC_COUNT(BC)) dut (
    .clk_32f(clk_32f),
    .reset_L(reset_L),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .byte_strobe(byte_strobe),
    .active(active)
  );
  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // The model remembers when the candidate boundary was found and treats every
  // edge a multiple of 8 bits later as a boundary, instead of a bit counter.
  task automatic model(input bit b, input bit rn);
    int nxt;
    if (!rn) begin
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);
      t_now = 0;
      anchor = -1;
      coms = 0;
      m_data = 8'h00;
      m_valid = 1'b0;
      m_strobe = 1'b0;
      m_act = 1'b0;
      return;
    end
    t_now++;
    hist.push_back(b);
    void'(hist.pop_front());
    nxt = 0;
    for (int i = 0; i < 8; i++) nxt = nxt * 2 + int'(hist[i]);
    m_strobe = 1'b0;
    if (anchor < 0) begin
      if (nxt == int'(COM)) begin
        anchor = t_now;
        coms = 1;
        if (BC == 1) m_act = 1'b1;
      end
    end else if ((t_now - anchor) % 8 == 0) begin
      if (m_act) begin
        m_strobe = 1'b1;
        if (nxt == int'(COM) || nxt == int'(IDL)) m_valid = 1'b0;
        else begin
          m_valid = 1'b1;
          m_data = 8'(nxt);
        end
      end else if (nxt == int'(COM)) begin
        coms++;
        if (coms == BC) m_act = 1'b1;
      end else begin
        anchor = -1;
        coms = 0;
      end
    end
  endtask
  task automatic step(input bit b, input bit rn);
    data_in = b;
    reset_L = rn;
    @(posedge clk_32f);
    model(b, rn);
    #1;
    if (byte_strobe) strobes++;
    check("cycle", {21'd0, active, byte_strobe, valid_out, data_out},
          {21'd0, m_act, m_strobe, m_valid, m_data});
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
  endtask
  task automatic rand_data(output logic [7:0] v);
    v = 8'($urandom);
    while (v == COM || v == IDL) v = 8'($urandom);
  endtask
  initial begin
    logic [7:0]  v;
    logic [31:0] word;
    vectors = 0;
    miscompares = 0;
    strobes = 0;
    data_in = 1'b0;
    reset_L = 1'b0;
    for (int i = 0; i < 4; i++) step(1'($urandom), 1'b0);
    check("reset_outputs", {active, byte_strobe, valid_out, data_out}, 11'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("idle_zero_inactive", {31'd0, active}, 32'd0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(COM);
    for (int i = 7; i > 0; i--) step(COM[i], 1'b1);
    check("lock_not_early", {31'd0, active}, 32'd0);
    step(COM[0], 1'b1);
    check("lock_at_cycle_35", {31'd0, active}, 32'd1);
    check("lock_no_valid", {31'd0, valid_out}, 32'd0);
    strobes = 0;
    send_byte(8'h12);
    check("data_12", {valid_out, data_out}, {1'b1, 8'h12});
    send_byte(IDL);
    check("idl_hold", {valid_out, data_out}, {1'b0, 8'h12});
    send_byte(8'hA5);
    check("data_a5", {valid_out, data_out}, {1'b1, 8'hA5});
    send_byte(COM);
    check("com_after_lock", {valid_out, data_out}, {1'b0, 8'hA5});
    check("strobe_count", strobes, 32'd4);
    send_byte(8'h3C);
    for (int i = 7; i > 4; i--) step(v[i] ^ 1'b1, 1'b1);
    step(1'($urandom), 1'b0);
    check("midbyte_reset", {active, byte_strobe, valid_out, data_out}, 11'd0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    check("relock_pending", {31'd0, active}, 32'd0);
    send_byte(COM);
    check("relock_done", {31'd0, active}, 32'd1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    send_byte(8'h55);
    check("align_reject", {31'd0, active}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    check("realign_pending", {31'd0, active}, 32'd0);
    send_byte(COM);
    check("realign_lock", {31'd0, active}, 32'd1);
    word = 32'h0321AE4F;
    for (int k = 3; k >= 0; k--) begin
      send_byte(word[k*8 +: 8]);
      check("loopback", {valid_out, data_out}, {1'b1, word[k*8 +: 8]});
    end
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < int'($urandom_range(3, 1)); i++) step(1'($urandom), 1'b0);
      for (int i = 0; i < int'($urandom_range(12, 0)); i++) step(1'($urandom), 1'b1);
      for (int i = 0; i < int'($urandom_range(BC + 1, BC - 1)); i++) send_byte(COM);
      for (int s = 0; s < int'($urandom_range(8, 2)); s++) begin
        case ($urandom_range(5, 0))
          0: v = IDL;
          1: v = COM;
          default: rand_data(v);
        endcase
        if ($urandom_range(15, 0) == 0) begin
          for (int i = 7; i > int'($urandom_range(7, 1)); i--) step(v[i], 1'b1);
          step(1'($urandom), 1'b0);
        end else send_byte(v);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
